// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder
//   Serialises a GRB frame held in an external shift register onto a WS2812B
//   data line. Each bit is one fixed-length period: high for T1H ('1') or
//   T0H ('0') clocks, then low for the rest of T_BIT. After N_BITS bits the line
//   is held low for T_RESET clocks so the LEDs latch, then frameDone pulses.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   start         in   frame request, sampled only in IDLE
//   registerBit   in   current MSB of the external shift register
//   loadRegister  out  one-cycle pulse: shift register loads its frame value
//   genDone       out  one-cycle pulse at the end of each bit: shift register rotates
//   dataOut       out  WS2812B serial line
//   busy          out  high in every state except IDLE
//   frameDone     out  one-cycle pulse in the final LATCH cycle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line low, waiting for start
// LOAD  | one cycle, loadRegister high; shift register takes the frame
// BIT   | one bit period per T_BIT clocks, idx counts bits in the frame
// LATCH | line low for T_RESET clocks, frameDone in the last cycle

module ws2812_bit_encoder #(
    parameter int T_BIT   = 125,
    parameter int T0H     = 40,
    parameter int T1H     = 80,
    parameter int T_RESET = 6000,
    parameter int N_BITS  = 96
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic registerBit,
    output logic loadRegister,
    output logic genDone,
    output logic dataOut,
    output logic busy,
    output logic frameDone
);

    // One counter serves both BIT and LATCH, so it is sized for the longer one.
    localparam int CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] HIGH_ZERO  = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] HIGH_ONE   = CNT_W'(T1H);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BIT   = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             bitReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            bitReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= BIT;
                    cnt   <= '0;
                    idx   <= '0;
                end
                BIT: begin
                    if (cnt == '0) begin
                        bitReg <= registerBit;
                    end
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= LATCH;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == RESET_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // bitReg is only captured at the end of the cnt=0 cycle, so that first
    // cycle has to look at the shift register output directly.
    logic             curBit;
    logic [CNT_W-1:0] highLen;

    assign curBit  = (cnt == '0) ? registerBit : bitReg;
    assign highLen = curBit ? HIGH_ONE : HIGH_ZERO;

    assign loadRegister = (state == LOAD);
    assign genDone      = (state == BIT) && (cnt == BIT_LAST);
    assign frameDone    = (state == LATCH) && (cnt == RESET_LAST);
    assign busy         = (state != IDLE);
    assign dataOut      = (state == BIT) && (cnt < highLen);

endmodule
